// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// The main entry drives the memory stage and the forwarding path.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  rd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic              out_zero,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic [REG_W-1:0]  out_rd,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   in_ready_q;
    logic   in_xfer;
    logic   out_xfer;
    logic   load_main;
    logic   load_skid;
    logic   move_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // x0 is hardwired to zero, so a write to it is never a real write.
    always_comb begin
        in_entry            = '0;
        in_entry.alu_result = alu_result;
        in_entry.zero       = zero;
        in_entry.store_data = store_data;
        in_entry.rd         = rd;
        in_entry.mem_read   = mem_read;
        in_entry.mem_write  = mem_write;
        in_entry.reg_write  = reg_write && (rd != '0);
        in_entry.mem_to_reg = mem_to_reg;
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = SKID;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    move_skid = 1'b1;
                    state_d   = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Reset and flush both discard everything; neither lets a transfer through.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
            if (load_main) begin
                main_q <= in_entry;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_alu_result = main_q.alu_result;
    assign out_store_data = main_q.store_data;
    assign out_zero       = main_q.zero;
    assign out_mem_read   = main_q.mem_read;
    assign out_mem_write  = main_q.mem_write;
    assign out_reg_write  = main_q.reg_write;
    assign out_mem_to_reg = main_q.mem_to_reg;
    assign out_rd         = main_q.rd;

    // Loads resolve in the memory stage, so only ALU results are forwarded.
    assign fwd_valid = out_valid && main_q.reg_write && !main_q.mem_to_reg;
    assign fwd_rd    = main_q.rd;
    assign fwd_data  = main_q.alu_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios then random traffic
// compared against a two-deep in-order queue model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic        out_zero;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        out_mem_to_reg;
    logic [4:0]  out_rd;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic        z;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .zero(zero),
        .store_data(store_data), .rd(rd),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result),
        .out_store_data(out_store_data),
        .out_zero(out_zero),
        .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write),
        .out_mem_to_reg(out_mem_to_reg),
        .out_rd(out_rd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        ent_t h;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            h = q[0];
            chk("out_alu_result", 64'(out_alu_result), 64'(h.alu));
            chk("out_store_data", 64'(out_store_data), 64'(h.sd));
            chk("out_flags",
                64'({out_zero, out_mem_read, out_mem_write,
                     out_reg_write, out_mem_to_reg}),
                64'({h.z, h.mr, h.mw, h.rw, h.m2r}));
            chk("out_rd", 64'(out_rd), 64'(h.rd));
            chk("fwd_valid", 64'(fwd_valid), 64'(h.rw && !h.m2r));
            chk("fwd_rd", 64'(fwd_rd), 64'(h.rd));
            chk("fwd_data", 64'(fwd_data), 64'(h.alu));
        end else begin
            chk("fwd_valid_empty", 64'(fwd_valid), 64'd0);
        end
    endtask

    // One clock: model applies the rules to the inputs seen at the edge.
    task automatic cyc();
        ent_t e;
        bit ix;
        bit ox;
        ix = in_valid && (q.size() < 2);
        ox = (q.size() > 0) && out_ready;
        e.alu = alu_result;
        e.sd  = store_data;
        e.z   = zero;
        e.rd  = rd;
        e.mr  = mem_read;
        e.mw  = mem_write;
        e.rw  = reg_write && (rd != 5'd0);
        e.m2r = mem_to_reg;
        @(posedge clk);
        #1;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(e);
        end
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [4:0] r, input logic w,
                         input logic m2r);
        in_valid   = v;
        alu_result = a;
        store_data = ~a;
        rd         = r;
        reg_write  = w;
        mem_to_reg = m2r;
        zero       = (a == 32'd0);
        mem_read   = m2r;
        mem_write  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {out_alu_result, out_store_data},
            64'd0);
        chk({tag, "_ctl"},
            64'({out_valid, out_zero, out_mem_read, out_mem_write,
                 out_reg_write, out_mem_to_reg, out_rd, fwd_valid,
                 fwd_rd, fwd_data}),
            64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        cyc();
        cyc();
        check_all_zero("reset_state");
        reset = 1'b0;

        // Single entry reaches the output one cycle later
        out_ready = 1'b1;
        drive(1'b1, 32'h10, 5'd3, 1'b1, 1'b0);
        cyc();
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_alu", 64'(out_alu_result), 64'h10);
        chk("basic_fwd", 64'({fwd_valid, fwd_rd}), 64'({1'b1, 5'd3}));
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        cyc();

        // Back-pressure fills the skid entry; drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd4, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h22, 5'd5, 1'b1, 1'b0);
        cyc();
        chk("skid_in_ready", 64'(in_ready), 64'd0);
        chk("skid_head", 64'(out_alu_result), 64'h11);
        drive(1'b1, 32'h33, 5'd6, 1'b1, 1'b0);
        cyc();
        chk("skid_hold", 64'(out_alu_result), 64'h11);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("drain_b", 64'(out_alu_result), 64'h22);
        cyc();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Streaming at full rate
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'(i), 5'd7, 1'b1, 1'b0);
            cyc();
            chk("stream_alu", 64'(out_alu_result), 64'(i));
            chk("stream_in_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        cyc();

        // Writes to x0 are suppressed
        drive(1'b1, 32'h55, 5'd0, 1'b1, 1'b0);
        cyc();
        chk("x0_rw", 64'({out_reg_write, fwd_valid}), 64'd0);
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        cyc();

        // Flush in skid state with a competing input
        out_ready = 1'b0;
        drive(1'b1, 32'h66, 5'd8, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 32'h77, 5'd9, 1'b1, 1'b0);
        cyc();
        flush = 1'b1;
        drive(1'b1, 32'h88, 5'd10, 1'b1, 1'b0);
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        cyc();
        chk("flush_no_emit", 64'(out_valid), 64'd0);

        // Load results are not forwarded; reset beats flush
        out_ready = 1'b0;
        drive(1'b1, 32'h99, 5'd11, 1'b1, 1'b1);
        cyc();
        chk("load_fwd", 64'({out_valid, fwd_valid}), 64'({1'b1, 1'b0}));
        drive(1'b1, 32'hAA, 5'd12, 1'b1, 1'b0);
        cyc();
        reset = 1'b1;
        flush = 1'b1;
        cyc();
        check_all_zero("reset_flush");
        reset = 1'b0;
        flush = 1'b0;

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            alu_result = $urandom;
            store_data = $urandom;
            zero       = $urandom_range(0, 1) == 1;
            rd         = ($urandom_range(0, 7) == 0) ? 5'd0
                         : 5'($urandom_range(1, 31));
            mem_read   = $urandom_range(0, 1) == 1;
            mem_write  = $urandom_range(0, 1) == 1;
            reg_write  = $urandom_range(0, 1) == 1;
            mem_to_reg = $urandom_range(0, 1) == 1;
            flush      = ($urandom_range(0, 29) == 0);
            reset      = ($urandom_range(0, 59) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
